// File: rtl/charging_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | charging_pkg                                                         |
// | Policy codes, report record widths and the saturating-count helper.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package charging_pkg;

    localparam int RPT_W    = 48;
    localparam int TS_W     = 24;
    localparam int REPORT_W = 22;

    localparam logic [2:0] POL_PASS     = 3'd0;
    localparam logic [2:0] POL_DROP     = 3'd1;
    localparam logic [2:0] POL_MARK     = 3'd2;
    localparam logic [2:0] POL_PASS_RPT = 3'd3;
    localparam logic [2:0] POL_DROP_RPT = 3'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/charging_rpt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | charging_rpt_fifo                                                    |
// | Synchronous report FIFO; head word read straight from flop storage.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module charging_rpt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                       asclk,
    input  logic                       areset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]     c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full is judged on the pre-pop count, so a same-cycle pop never makes room.
    assign w_do_push = push && (r_count != c_FULL);
    assign w_do_pop  = pop && (r_count != '0);

    always_ff @(posedge asclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + c_CNT_ONE;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge asclk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/charging_policy_enforcer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | charging_policy_enforcer                                             |
// | Applies forward/drop/mark policy, queues timestamped reports, stats. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module charging_policy_enforcer
    import charging_pkg::*;
#(
    parameter int RPT_DEPTH = 8,
    parameter int RPT_BLOCK = 1
) (
    input  logic                 asclk,
    input  logic                 areset,
    input  logic [TS_W-1:0]      timer,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [15:0]          in_pkt_len,
    input  logic [95:0]          in_pkt_id,
    input  logic [2:0]           in_cnt_policy,
    input  logic                 in_ul,
    input  logic [REPORT_W-1:0]  in_cnt_report,
    input  logic                 in_cnt_en,
    output logic                 pkt_vld,
    input  logic                 pkt_rdy,
    output logic [15:0]          pkt_len,
    output logic [95:0]          pkt_id,
    output logic                 pkt_ul,
    output logic                 pkt_mark,
    output logic                 rpt_vld,
    input  logic                 rpt_rdy,
    output logic [RPT_W-1:0]     rpt_data,
    input  logic                 cnt_clr,
    output logic [31:0]          drop_cnt,
    output logic [31:0]          rpt_lost_cnt,
    output logic [31:0]          bad_pol_cnt
);

    localparam int              c_CW   = $clog2(RPT_DEPTH) + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(RPT_DEPTH);

    logic [2:0]        w_eff_pol;
    logic              w_pol_legal;
    logic              w_is_drop;
    logic              w_is_rpt;
    logic              w_is_mark;
    logic              w_is_bad;
    logic              w_pkt_free;
    logic              w_rpt_ok;
    logic              w_fifo_full;
    logic              w_acc;
    logic              w_push;
    logic              w_lost;
    logic [c_CW-1:0]   w_fifo_count;
    logic [RPT_W-1:0]  w_rpt_rec;

    logic              r_pkt_vld;
    logic [15:0]       r_pkt_len;
    logic [95:0]       r_pkt_id;
    logic              r_pkt_ul;
    logic              r_pkt_mark;
    logic [31:0]       r_drop_cnt;
    logic [31:0]       r_rpt_lost_cnt;
    logic [31:0]       r_bad_pol_cnt;

    // Uncharged or illegal codes collapse to plain PASS.
    always_comb begin
        w_pol_legal = (in_cnt_policy <= POL_DROP_RPT);
        w_eff_pol   = POL_PASS;
        if (in_cnt_en && w_pol_legal)
            w_eff_pol = in_cnt_policy;
        w_is_drop = (w_eff_pol == POL_DROP) || (w_eff_pol == POL_DROP_RPT);
        w_is_rpt  = (w_eff_pol == POL_PASS_RPT) || (w_eff_pol == POL_DROP_RPT);
        w_is_mark = (w_eff_pol == POL_MARK);
        w_is_bad  = in_cnt_en && !w_pol_legal;
    end

    assign w_fifo_full = (w_fifo_count == c_FULL);
    assign w_pkt_free  = !r_pkt_vld || pkt_rdy;
    assign w_rpt_ok    = (RPT_BLOCK == 0) || !w_fifo_full;
    assign in_rdy      = w_pkt_free && w_rpt_ok;
    assign w_acc       = in_vld && in_rdy;
    assign w_push      = w_acc && w_is_rpt && !w_fifo_full;
    assign w_lost      = w_acc && w_is_rpt && w_fifo_full;
    assign w_rpt_rec   = {timer, in_ul, 1'b0, in_cnt_report};

    always_ff @(posedge asclk) begin
        if (areset) begin
            r_pkt_vld <= 1'b0;
        end else if (w_acc && !w_is_drop) begin
            r_pkt_vld <= 1'b1;
        end else if (pkt_rdy) begin
            r_pkt_vld <= 1'b0;
        end
    end

    always_ff @(posedge asclk) begin
        if (w_acc && !w_is_drop) begin
            r_pkt_len  <= in_pkt_len;
            r_pkt_id   <= in_pkt_id;
            r_pkt_ul   <= in_ul;
            r_pkt_mark <= w_is_mark;
        end
    end

    always_ff @(posedge asclk) begin
        if (areset || cnt_clr) begin
            r_drop_cnt     <= '0;
            r_rpt_lost_cnt <= '0;
            r_bad_pol_cnt  <= '0;
        end else begin
            if (w_acc && w_is_drop)
                r_drop_cnt <= sat_inc(r_drop_cnt);
            if (w_lost)
                r_rpt_lost_cnt <= sat_inc(r_rpt_lost_cnt);
            if (w_acc && w_is_bad)
                r_bad_pol_cnt <= sat_inc(r_bad_pol_cnt);
        end
    end

    charging_rpt_fifo #(
        .DEPTH (RPT_DEPTH),
        .WIDTH (RPT_W)
    ) u_rpt_fifo (
        .asclk     (asclk),
        .areset    (areset),
        .push      (w_push),
        .push_data (w_rpt_rec),
        .pop       (rpt_rdy),
        .pop_data  (rpt_data),
        .count     (w_fifo_count)
    );

    assign rpt_vld      = (w_fifo_count != '0);
    assign pkt_vld      = r_pkt_vld;
    assign pkt_len      = r_pkt_len;
    assign pkt_id       = r_pkt_id;
    assign pkt_ul       = r_pkt_ul;
    assign pkt_mark     = r_pkt_mark;
    assign drop_cnt     = r_drop_cnt;
    assign rpt_lost_cnt = r_rpt_lost_cnt;
    assign bad_pol_cnt  = r_bad_pol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_charging_policy_enforcer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_charging_policy_enforcer                                          |
// | Blocking and non-blocking instances share stimulus; queue model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_charging_policy_enforcer;

    localparam int DEPTH = 8;

    logic         asclk = 1'b0;
    logic         areset;
    logic [23:0]  timer;
    logic         in_vld;
    logic [15:0]  in_pkt_len;
    logic [95:0]  in_pkt_id;
    logic [2:0]   in_cnt_policy;
    logic         in_ul;
    logic [21:0]  in_cnt_report;
    logic         in_cnt_en;
    logic         pkt_rdy;
    logic         rpt_rdy;
    logic         cnt_clr;

    logic [1:0]   d_in_rdy;
    logic [1:0]   d_pkt_vld;
    logic [15:0]  d_pkt_len  [2];
    logic [95:0]  d_pkt_id   [2];
    logic [1:0]   d_pkt_ul;
    logic [1:0]   d_pkt_mark;
    logic [1:0]   d_rpt_vld;
    logic [47:0]  d_rpt_data [2];
    logic [31:0]  d_drop     [2];
    logic [31:0]  d_lost     [2];
    logic [31:0]  d_bad      [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 asclk = ~asclk;

    // Instance 0 stalls on a full report FIFO, instance 1 discards reports.
    charging_policy_enforcer #(.RPT_DEPTH(DEPTH), .RPT_BLOCK(1)) u_dut_blk (
        .asclk(asclk), .areset(areset), .timer(timer),
        .in_vld(in_vld), .in_rdy(d_in_rdy[0]), .in_pkt_len(in_pkt_len),
        .in_pkt_id(in_pkt_id), .in_cnt_policy(in_cnt_policy), .in_ul(in_ul),
        .in_cnt_report(in_cnt_report), .in_cnt_en(in_cnt_en),
        .pkt_vld(d_pkt_vld[0]), .pkt_rdy(pkt_rdy), .pkt_len(d_pkt_len[0]),
        .pkt_id(d_pkt_id[0]), .pkt_ul(d_pkt_ul[0]), .pkt_mark(d_pkt_mark[0]),
        .rpt_vld(d_rpt_vld[0]), .rpt_rdy(rpt_rdy), .rpt_data(d_rpt_data[0]),
        .cnt_clr(cnt_clr), .drop_cnt(d_drop[0]), .rpt_lost_cnt(d_lost[0]),
        .bad_pol_cnt(d_bad[0])
    );

    charging_policy_enforcer #(.RPT_DEPTH(DEPTH), .RPT_BLOCK(0)) u_dut_nb (
        .asclk(asclk), .areset(areset), .timer(timer),
        .in_vld(in_vld), .in_rdy(d_in_rdy[1]), .in_pkt_len(in_pkt_len),
        .in_pkt_id(in_pkt_id), .in_cnt_policy(in_cnt_policy), .in_ul(in_ul),
        .in_cnt_report(in_cnt_report), .in_cnt_en(in_cnt_en),
        .pkt_vld(d_pkt_vld[1]), .pkt_rdy(pkt_rdy), .pkt_len(d_pkt_len[1]),
        .pkt_id(d_pkt_id[1]), .pkt_ul(d_pkt_ul[1]), .pkt_mark(d_pkt_mark[1]),
        .rpt_vld(d_rpt_vld[1]), .rpt_rdy(rpt_rdy), .rpt_data(d_rpt_data[1]),
        .cnt_clr(cnt_clr), .drop_cnt(d_drop[1]), .rpt_lost_cnt(d_lost[1]),
        .bad_pol_cnt(d_bad[1])
    );

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, k, act, exp);
        end
    endtask

    // Behavioural model: packet slot, report queue and counters per instance.
    bit           m_init = 1'b0;
    bit           m_pv   [2];
    logic [15:0]  m_len  [2];
    logic [95:0]  m_id   [2];
    logic         m_ul   [2];
    logic         m_mark [2];
    logic [47:0]  mq     [2][$];
    logic [31:0]  m_drop [2];
    logic [31:0]  m_lost [2];
    logic [31:0]  m_bad  [2];

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    always @(negedge asclk) begin
        for (int k = 0; k < 2; k++) begin
            bit       e_rdy, acc, full, wants_rpt, drops;
            int       pol;
            e_rdy = (!m_pv[k] || pkt_rdy) && ((k == 1) || (mq[k].size() < DEPTH));
            if (m_init) begin
                chk("in_rdy", k, d_in_rdy[k], e_rdy);
                chk("pkt_vld", k, d_pkt_vld[k], m_pv[k]);
                if (m_pv[k]) begin
                    chk("pkt_len", k, d_pkt_len[k], m_len[k]);
                    chk("pkt_id", k, d_pkt_id[k], m_id[k]);
                    chk("pkt_ul", k, d_pkt_ul[k], m_ul[k]);
                    chk("pkt_mark", k, d_pkt_mark[k], m_mark[k]);
                end
                chk("rpt_vld", k, d_rpt_vld[k], mq[k].size() > 0);
                if (mq[k].size() > 0)
                    chk("rpt_data", k, d_rpt_data[k], mq[k][0]);
                chk("drop_cnt", k, d_drop[k], m_drop[k]);
                chk("rpt_lost_cnt", k, d_lost[k], m_lost[k]);
                chk("bad_pol_cnt", k, d_bad[k], m_bad[k]);
            end
            if (areset) begin
                m_pv[k] = 0;
                mq[k].delete();
                m_drop[k] = 0; m_lost[k] = 0; m_bad[k] = 0;
                if (k == 1) m_init = 1'b1;
            end else begin
                acc = in_vld && e_rdy;
                pol = (in_cnt_en && in_cnt_policy <= 4) ? int'(in_cnt_policy) : 0;
                wants_rpt = (pol == 3) || (pol == 4);
                drops = (pol == 1) || (pol == 4);
                full = (mq[k].size() == DEPTH);
                if (mq[k].size() > 0 && rpt_rdy)
                    void'(mq[k].pop_front());
                if (acc && wants_rpt && !full)
                    mq[k].push_back({timer, in_ul, 1'b0, in_cnt_report});
                if (acc && !drops) begin
                    m_pv[k] = 1; m_len[k] = in_pkt_len; m_id[k] = in_pkt_id;
                    m_ul[k] = in_ul; m_mark[k] = (pol == 2);
                end else if (pkt_rdy) begin
                    m_pv[k] = 0;
                end
                if (cnt_clr) begin
                    m_drop[k] = 0; m_lost[k] = 0; m_bad[k] = 0;
                end else begin
                    if (acc && drops) m_drop[k] = sat1(m_drop[k]);
                    if (acc && wants_rpt && full) m_lost[k] = sat1(m_lost[k]);
                    if (acc && in_cnt_en && in_cnt_policy > 4) m_bad[k] = sat1(m_bad[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge asclk);
        #1;
        timer = timer + 24'd1;
    endtask

    task automatic beat(input logic [2:0] pol, input logic [15:0] len);
        in_vld = 1'b1;
        in_cnt_policy = pol;
        in_cnt_en = 1'b1;
        in_pkt_len = len;
        in_pkt_id = {$urandom, $urandom, $urandom};
        in_ul = 1'($urandom);
        in_cnt_report = 22'($urandom);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    initial begin
        int rr_pct, pr_pct;
        areset = 1'b1; timer = '0; in_vld = 0; in_pkt_len = '0; in_pkt_id = '0;
        in_cnt_policy = '0; in_ul = 0; in_cnt_report = '0; in_cnt_en = 0;
        pkt_rdy = 1'b1; rpt_rdy = 1'b1; cnt_clr = 1'b0;
        repeat (2) tick();
        areset = 1'b0;
        @(negedge asclk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_pkt_vld", k, d_pkt_vld[k], 0);
            chk("reset_rpt_vld", k, d_rpt_vld[k], 0);
            chk("reset_drop", k, d_drop[k], 0);
        end
        tick();

        for (int i = 0; i < 10; i++) begin beat(3'd0, 16'(100 + i)); tick(); end
        in_vld = 0; tick();
        for (int i = 0; i < 10; i++) begin beat((i % 2) ? 3'd2 : 3'd1, 16'd64); tick(); end
        in_vld = 0; tick();
        @(negedge asclk);
        for (int k = 0; k < 2; k++) chk("t2_drop_cnt", k, d_drop[k], 5);
        chk("t2_model_drop", 0, m_drop[0], 5);

        do_reset();
        rpt_rdy = 1'b0;
        beat(3'd3, 16'd40);
        in_ul = 1'b1; in_cnt_report = 22'h2ABCD; timer = 24'h000100;
        tick();
        in_vld = 1'b0;
        @(negedge asclk);
        for (int k = 0; k < 2; k++) begin
            chk("t3_rpt_vld", k, d_rpt_vld[k], 1);
            chk("t3_rpt_data", k, d_rpt_data[k], 48'h000100_82ABCD);
            chk("t3_pkt_vld", k, d_pkt_vld[k], 1);
        end
        chk("t3_model_rpt", 0, mq[0][0], 48'h000100_82ABCD);
        tick();

        for (int i = 0; i < 8; i++) begin
            beat(3'd3, 16'd50);
            if (i == 7) begin
                @(negedge asclk);
                chk("t4_stall_blk", 0, d_in_rdy[0], 0);
                chk("t4_open_nb", 1, d_in_rdy[1], 1);
            end
            tick();
        end
        in_vld = 1'b0;
        tick();
        @(negedge asclk);
        chk("t5_lost_nb", 1, d_lost[1], 1);
        chk("t4_lost_blk", 0, d_lost[0], 0);
        rpt_rdy = 1'b1;
        beat(3'd3, 16'd51);
        tick();
        in_vld = 1'b0;
        repeat (12) tick();

        beat(3'd7, 16'd77); tick();
        in_vld = 1'b0;
        @(negedge asclk);
        for (int k = 0; k < 2; k++) chk("t5_bad_pol", k, d_bad[k], 1);
        tick();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        @(negedge asclk);
        for (int k = 0; k < 2; k++) begin
            chk("t5_clr_bad", k, d_bad[k], 0);
            chk("t5_clr_lost", k, d_lost[k], 0);
        end
        tick();

        pkt_rdy = 1'b0;
        beat(3'd0, 16'd300); tick();
        for (int i = 0; i < 5; i++) begin
            beat(3'd0, 16'd301);
            @(negedge asclk);
            chk("t6_stall_rdy", 0, d_in_rdy[0], 0);
            chk("t6_stall_len", 0, d_pkt_len[0], 16'd300);
            tick();
        end
        in_vld = 1'b0;
        do_reset();
        @(negedge asclk);
        for (int k = 0; k < 2; k++) begin
            chk("t6_rst_pkt_vld", k, d_pkt_vld[k], 0);
            chk("t6_rst_rpt_vld", k, d_rpt_vld[k], 0);
        end
        tick();
        pkt_rdy = 1'b1;

        rr_pct = 50; pr_pct = 75;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                rr_pct = $urandom_range(5, 95);
                pr_pct = $urandom_range(30, 100);
            end
            in_vld = ($urandom_range(0, 3) != 0);
            in_cnt_policy = 3'($urandom);
            in_cnt_en = ($urandom_range(0, 7) != 0);
            in_pkt_len = 16'($urandom);
            in_pkt_id = {$urandom, $urandom, $urandom};
            in_ul = 1'($urandom);
            in_cnt_report = 22'($urandom);
            pkt_rdy = ($urandom_range(0, 99) < pr_pct);
            rpt_rdy = ($urandom_range(0, 99) < rr_pct);
            cnt_clr = ($urandom_range(0, 199) == 0);
            areset = ($urandom_range(0, 999) == 0);
            tick();
        end
        areset = 1'b0; in_vld = 1'b0; cnt_clr = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
